ahb_bridge_arbiter: RTL

- Multi-master AHB arbiter in front of Bridge_Top's AHB slave port.
- Shares the single AHB-to-APB bridge between NUM_MASTERS AHB masters.
- Grants the bus round-robin, holds grant across bursts and caps back-to-back singles.
- Muxes the address-phase and data-phase signals of the owning masters onto the bridge inputs.

---
 rtl/ahb_bridge_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin AHB arbiter sharing one AHB-to-APB bridge slave port between NUM_MASTERS masters.
// Grant is registered (1 cycle), Hmaster follows it by one ready cycle and Hmaster_d by two; Hreadyout=0 freezes all state.
module ahb_bridge_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int MAX_BEATS   = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic                      Hclk,
  input  logic                      Hreset,
  input  logic [NUM_MASTERS-1:0]    Hbusreq,
  input  logic [2*NUM_MASTERS-1:0]  Htrans_m,
  input  logic [AW*NUM_MASTERS-1:0] Haddr_m,
  input  logic [NUM_MASTERS-1:0]    Hwrite_m,
  input  logic [DW*NUM_MASTERS-1:0] Hwdata_m,
  input  logic                      Hreadyout,
  output logic [NUM_MASTERS-1:0]    Hgrant,
  output logic [2:0]                Hmaster,
  output logic [2:0]                Hmaster_d,
  output logic [1:0]                Htrans,
  output logic [AW-1:0]             Haddr,
  output logic                      Hwrite,
  output logic [DW-1:0]             Hwdata,
  output logic                      Hreadyin,
  output logic                      Hready_m
);

  localparam int            CW    = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BEATS);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  typedef enum logic [1:0] {PARK, OWN, BURST} state_t;

  function automatic logic [2:0] oh_idx(input logic [NUM_MASTERS-1:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (((v >> i) & NUM_MASTERS'(1)) != '0) r = 3'(i);
    end
    return r;
  endfunction

  // First requester strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [2:0] rr_pick(input logic [NUM_MASTERS-1:0] req, input logic [2:0] ptr);
    logic [2:0] pick;
    logic       found;
    int         j;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      j = (int'(ptr) + k) % NUM_MASTERS;
      if (!found && (((req >> j) & NUM_MASTERS'(1)) != '0)) begin
        pick  = 3'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [2:0]             hmaster_q, hmaster_dq;
  logic [2:0]             grant_idx, rr_idx;
  logic [NUM_MASTERS-1:0] own_mask;
  logic                   owner_req, others_req, any_req, in_burst;
  logic [1:0]             trans_sel;

  assign grant_idx  = oh_idx(grant_q);
  assign rr_idx     = rr_pick(Hbusreq, ptr_q);
  assign own_mask   = NUM_MASTERS'(1) << hmaster_q;
  assign owner_req  = |(Hbusreq & own_mask);
  assign others_req = |(Hbusreq & ~own_mask);
  assign any_req    = |Hbusreq;

  assign trans_sel = 2'(Htrans_m >> (2 * hmaster_q));
  assign Htrans    = (state_q == PARK && !owner_req) ? IDLE : trans_sel;
  assign Haddr     = AW'(Haddr_m >> (AW * hmaster_q));
  assign Hwrite    = |(Hwrite_m & own_mask);
  assign Hwdata    = DW'(Hwdata_m >> (DW * hmaster_dq));

  assign Hgrant    = grant_q;
  assign Hmaster   = hmaster_q;
  assign Hmaster_d = hmaster_dq;
  assign Hreadyin  = Hreadyout;
  assign Hready_m  = Hreadyout;

  assign in_burst = (Htrans == SEQ) || (Htrans == BUSY);
  assign cnt_inc  = (Htrans == NONSEQ && cnt_q < MAX_C) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (!any_req && !in_burst) begin
      state_d = PARK;
      grant_d = NUM_MASTERS'(1);
    end else begin
      case (state_q)
        PARK: begin
          if (any_req) begin
            state_d = OWN;
            grant_d = NUM_MASTERS'(1) << rr_idx;
            ptr_d   = rr_idx;
          end
        end
        default: begin
          // During handover the bus still carries the previous owner, so the new grant is left alone.
          if (grant_idx != hmaster_q) begin
            state_d = OWN;
          end else if (in_burst) begin
            state_d = BURST;
          end else if (owner_req && (!others_req || cnt_inc < MAX_C)) begin
            state_d = OWN;
          end else begin
            state_d = OWN;
            grant_d = NUM_MASTERS'(1) << rr_idx;
            ptr_d   = rr_idx;
          end
        end
      endcase
    end
    cnt_d = (grant_d != grant_q) ? '0 : cnt_inc;
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q    <= PARK;
      grant_q    <= NUM_MASTERS'(1);
      ptr_q      <= '0;
      cnt_q      <= '0;
      hmaster_q  <= '0;
      hmaster_dq <= '0;
    end else if (Hreadyout) begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      hmaster_q  <= grant_idx;
      hmaster_dq <= hmaster_q;
    end
  end

endmodule
